hdlc_tx_frame_ctrl: RTL and testbench
=====================================

// Module: hdlc_tx_frame_ctrl
// PURPOSE
//  Frame sequencer for the HDLC Tx datapath. Between the Tx buffer/register file and the Tx bit shifter.
//  On a start request it orders the shifter through: opening flag -> N buffer bytes -> FCS -> closing flag.
//  Drives buffer reads, FCS start/write and zero-insert enable. Handles abort, frame-size checks and status.
// PARAMETERS
//  MAX_FRAME_SIZE  126  largest legal Tx_FrameSize in bytes (Tx buffer depth)
//  TIMEOUT_CYCLES  64   watchdog limit in cycles; used only with TX_CTRL_TIMEOUT_EN
// PORTS
//  Clk              in   1  system clock; single clock domain
//  Rst              in   1  synchronous, active-high reset
//  Tx_Enable        in   1  start-frame pulse from the control register
//  Tx_AbortFrame    in   1  abort request pulse from the control register
//  Tx_FrameSize     in   8  bytes to send; sampled when a start is accepted
//  Tx_NewByte       in   1  pulse from shifter: it has finished the current byte/flag/abort and is ready
//  Tx_FCSDone       in   1  pulse from shifter: both FCS bytes have been shifted out
//  Tx_ValidFrame    out  1  a frame is in progress (opening flag through closing flag)
//  Tx_SendFlag      out  1  one-cycle pulse: shifter loads 0x7E
//  Tx_SendAbort     out  1  one-cycle pulse: shifter loads the abort pattern (0x7F)
//  Tx_RdBuff        out  1  one-cycle pulse: pop one byte from the Tx buffer
//  Tx_StartFCS      out  1  one-cycle pulse: clear and start the FCS generator
//  Tx_WriteFCS      out  1  one-cycle pulse: shifter loads the FCS bytes
//  Tx_InitZero      out  1  level: zero insertion enabled (data and FCS only)
//  Tx_AbortedTrans  out  1  sticky: last frame was aborted
//  Tx_Done          out  1  level: controller idle, buffer fully consumed
//  Tx_ByteCnt       out  8  bytes popped in the current/last frame
//  Tx_Timeout       out  1  sticky: watchdog fired (tied 0 without macro)
// BEHAVIOUR
//  - All outputs are registered. Responses appear 1 cycle after the causing input.
//  - Reset values: Tx_Done=1, Tx_ByteCnt=0, every other output 0, state IDLE.
//    Reset mid-frame abandons the frame with no abort pattern and clears the sticky flags.
//  - States: IDLE, SFLAG, DATA, FCS, EFLAG, ABORT.
//  - IDLE: on Tx_Enable with 1 <= Tx_FrameSize <= MAX_FRAME_SIZE -> SFLAG.
//    Entry actions: Tx_SendFlag, Tx_StartFCS; Tx_ValidFrame=1, Tx_Done=0.
//    Also clears Tx_ByteCnt, Tx_AbortedTrans and Tx_Timeout, and latches the size.
//    Size 0 or > MAX_FRAME_SIZE: request ignored, all outputs unchanged.
//  - SFLAG: on Tx_NewByte -> DATA. Pulse Tx_RdBuff, set Tx_InitZero=1, Tx_ByteCnt=1.
//  - DATA: on Tx_NewByte:
//      if Tx_ByteCnt < size: pulse Tx_RdBuff, Tx_ByteCnt++.
//      else: -> FCS, pulse Tx_WriteFCS.
//  - FCS: on Tx_FCSDone -> EFLAG. Pulse Tx_SendFlag, Tx_InitZero=0.
//    Tx_NewByte in FCS is ignored; Tx_FCSDone has priority if both arrive together.
//  - EFLAG: on Tx_NewByte -> IDLE. Tx_ValidFrame=0, Tx_Done=1.
//  - Abort: Tx_AbortFrame in any non-IDLE, non-ABORT state -> ABORT.
//    Entry actions: pulse Tx_SendAbort; Tx_AbortedTrans=1, Tx_ValidFrame=0, Tx_InitZero=0.
//    Abort beats every simultaneous event, including the last Tx_NewByte of a state.
//    Ignored in IDLE and ABORT.
//  - ABORT: on Tx_NewByte -> IDLE, Tx_Done=1. Tx_ByteCnt holds the bytes popped so far.
//  - Tx_Enable while not in IDLE is ignored; the latched size is never modified mid-frame.
//  - Tx_ByteCnt never exceeds the latched size. Exactly size Tx_RdBuff pulses per completed frame.
//  - Tx_StartFCS is never asserted in the same cycle as Tx_WriteFCS.
// CONFIGURATION
//  TX_CTRL_TIMEOUT_EN defined:
//    Watchdog counter of width $clog2(TIMEOUT_CYCLES+1), cleared on every state change.
//    Counts in SFLAG/DATA/FCS/EFLAG/ABORT.
//    Reaching TIMEOUT_CYCLES -> Tx_Timeout=1 (sticky).
//    From SFLAG/DATA/FCS/EFLAG: take the abort path, Tx_AbortedTrans=1.
//    From ABORT: force IDLE, Tx_Done=1.
//  Not defined: no watchdog logic; Tx_Timeout tied 0; controller waits indefinitely.
// TESTING
//  1. Size=3, Tx_NewByte every 8 cycles, Tx_FCSDone 16 cycles after Tx_WriteFCS ->
//     SendFlag, 3 RdBuff, WriteFCS, SendFlag; Tx_ByteCnt=3; Tx_Done=1; Tx_AbortedTrans=0.
//  2. Tx_Enable with size=0, then size=127 -> no output changes; Tx_Done stays 1.
//  3. Size=10, Tx_AbortFrame after 4th RdBuff -> SendAbort 1 cycle later, ValidFrame=0, AbortedTrans=1;
//     Tx_Done=1 after next Tx_NewByte; Tx_ByteCnt=4.
//  4. Tx_AbortFrame and Tx_NewByte in the same DATA cycle -> SendAbort only, no RdBuff;
//     Tx_Enable during the frame is ignored.
//  5. Rst asserted in DATA with size=5 -> next edge: Tx_Done=1, Tx_ByteCnt=0, all others 0;
//     a new size=1 frame then completes normally.
//  6. Macro on, TIMEOUT_CYCLES=64, Tx_FCSDone withheld -> 64 cycles after WriteFCS:
//     Tx_Timeout=1, SendAbort, AbortedTrans=1.
//     Macro off -> controller remains in FCS, Tx_Timeout=0.

Source files
------------

// File: rtl/hdlc_tx_frame_ctrl.sv
// hdlc_tx_frame_ctrl
// Frame sequencer for the HDLC Tx path. Sequences the bit shifter through
// opening flag, buffer bytes, FCS and closing flag. It also handles abort
// requests and frame-size checks.
// Optional feature: define TX_CTRL_TIMEOUT_EN to build the per-state watchdog.
// Without it, Tx_Timeout is tied low and the controller can wait indefinitely.
module hdlc_tx_frame_ctrl #(
    parameter int MAX_FRAME_SIZE = 126,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic       Tx_AbortFrame,
    input  logic [7:0] Tx_FrameSize,
    input  logic       Tx_NewByte,
    input  logic       Tx_FCSDone,
    output logic       Tx_ValidFrame,
    output logic       Tx_SendFlag,
    output logic       Tx_SendAbort,
    output logic       Tx_RdBuff,
    output logic       Tx_StartFCS,
    output logic       Tx_WriteFCS,
    output logic       Tx_InitZero,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Done,
    output logic [7:0] Tx_ByteCnt,
    output logic       Tx_Timeout
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SFLAG = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_FCS   = 3'd3;
    localparam logic [2:0] S_EFLAG = 3'd4;
    localparam logic [2:0] S_ABORT = 3'd5;

    localparam logic [7:0] MAX_SZ = 8'(MAX_FRAME_SIZE);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [7:0] r_size;
    logic [7:0] r_byte_cnt;
    logic       r_valid;
    logic       r_send_flag;
    logic       r_send_abort;
    logic       r_rd_buff;
    logic       r_start_fcs;
    logic       r_write_fcs;
    logic       r_init_zero;
    logic       r_aborted;
    logic       r_done;
    logic       w_size_ok;
    logic       w_in_frame;
    logic       w_wd_fire;

    assign w_size_ok  = (Tx_FrameSize != 8'd0) && (Tx_FrameSize <= MAX_SZ);
    assign w_in_frame = (r_state != S_IDLE) && (r_state != S_ABORT);

    // Next-state selection. An abort or watchdog event wins over every other event in a frame state.
    always_comb begin
        w_state_nxt = r_state;
        if (w_in_frame && (Tx_AbortFrame || w_wd_fire)) begin
            w_state_nxt = S_ABORT;
        end else begin
            case (r_state)
                S_IDLE:  if (Tx_Enable && w_size_ok) w_state_nxt = S_SFLAG;
                S_SFLAG: if (Tx_NewByte) w_state_nxt = S_DATA;
                S_DATA:  if (Tx_NewByte && !(r_byte_cnt < r_size)) w_state_nxt = S_FCS;
                S_FCS:   if (Tx_FCSDone) w_state_nxt = S_EFLAG;
                S_EFLAG: if (Tx_NewByte) w_state_nxt = S_IDLE;
                S_ABORT: if (Tx_NewByte || w_wd_fire) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State register plus registered outputs. Entry actions are keyed on the target state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_size       <= 8'd0;
            r_byte_cnt   <= 8'd0;
            r_valid      <= 1'b0;
            r_send_flag  <= 1'b0;
            r_send_abort <= 1'b0;
            r_rd_buff    <= 1'b0;
            r_start_fcs  <= 1'b0;
            r_write_fcs  <= 1'b0;
            r_init_zero  <= 1'b0;
            r_aborted    <= 1'b0;
            r_done       <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_send_flag  <= 1'b0;
            r_send_abort <= 1'b0;
            r_rd_buff    <= 1'b0;
            r_start_fcs  <= 1'b0;
            r_write_fcs  <= 1'b0;
            if (w_state_nxt != r_state) begin
                case (w_state_nxt)
                    S_SFLAG: begin
                        r_send_flag <= 1'b1;
                        r_start_fcs <= 1'b1;
                        r_valid     <= 1'b1;
                        r_done      <= 1'b0;
                        r_byte_cnt  <= 8'd0;
                        r_aborted   <= 1'b0;
                        r_size      <= Tx_FrameSize;
                    end
                    S_DATA: begin
                        r_rd_buff   <= 1'b1;
                        r_init_zero <= 1'b1;
                        r_byte_cnt  <= 8'd1;
                    end
                    S_FCS: begin
                        r_write_fcs <= 1'b1;
                    end
                    S_EFLAG: begin
                        r_send_flag <= 1'b1;
                        r_init_zero <= 1'b0;
                    end
                    S_ABORT: begin
                        r_send_abort <= 1'b1;
                        r_aborted    <= 1'b1;
                        r_valid      <= 1'b0;
                        r_init_zero  <= 1'b0;
                    end
                    S_IDLE: begin
                        r_valid     <= 1'b0;
                        r_init_zero <= 1'b0;
                        r_done      <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (r_state == S_DATA && Tx_NewByte) begin
                // Staying in DATA on a byte boundary means more bytes remain.
                r_rd_buff  <= 1'b1;
                r_byte_cnt <= r_byte_cnt + 8'd1;
            end
        end
    end

`ifdef TX_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd;
    logic            r_timeout;

    // The watchdog fires on the cycle that would take the counter to TIMEOUT_CYCLES.
    assign w_wd_fire = (r_state != S_IDLE) && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter restarts on every state change. The sticky flag clears on a new frame.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_state_nxt != r_state)
                r_wd <= '0;
            else if (r_state != S_IDLE)
                r_wd <= r_wd + 1'b1;
            if (r_state == S_IDLE && w_state_nxt == S_SFLAG)
                r_timeout <= 1'b0;
            else if (w_wd_fire)
                r_timeout <= 1'b1;
        end
    end

    assign Tx_Timeout = r_timeout;
`else
    assign w_wd_fire  = 1'b0;
    assign Tx_Timeout = 1'b0;
`endif

    assign Tx_ValidFrame   = r_valid;
    assign Tx_SendFlag     = r_send_flag;
    assign Tx_SendAbort    = r_send_abort;
    assign Tx_RdBuff       = r_rd_buff;
    assign Tx_StartFCS     = r_start_fcs;
    assign Tx_WriteFCS     = r_write_fcs;
    assign Tx_InitZero     = r_init_zero;
    assign Tx_AbortedTrans = r_aborted;
    assign Tx_Done         = r_done;
    assign Tx_ByteCnt      = r_byte_cnt;

endmodule

// File: tb/tb_hdlc_tx_frame_ctrl.sv
// Bench for hdlc_tx_frame_ctrl.
// Each vector row has the following parts:
//  - inputs for one cycle,
//  - the pulse set expected one cycle later, which goes to a scoreboard queue,
//  - the level outputs checked right after the edge,
//  - an idle gap.
// A monitor pops the queue whenever any pulse output fires.
module tb_hdlc_tx_frame_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Tx_Enable = 1'b0;
    logic       Tx_AbortFrame = 1'b0;
    logic [7:0] Tx_FrameSize = 8'd0;
    logic       Tx_NewByte = 1'b0;
    logic       Tx_FCSDone = 1'b0;
    logic       Tx_ValidFrame, Tx_SendFlag, Tx_SendAbort, Tx_RdBuff, Tx_StartFCS;
    logic       Tx_WriteFCS, Tx_InitZero, Tx_AbortedTrans, Tx_Done, Tx_Timeout;
    logic [7:0] Tx_ByteCnt;

    hdlc_tx_frame_ctrl dut (
        .Clk(Clk), .Rst(Rst), .Tx_Enable(Tx_Enable), .Tx_AbortFrame(Tx_AbortFrame),
        .Tx_FrameSize(Tx_FrameSize), .Tx_NewByte(Tx_NewByte), .Tx_FCSDone(Tx_FCSDone),
        .Tx_ValidFrame(Tx_ValidFrame), .Tx_SendFlag(Tx_SendFlag), .Tx_SendAbort(Tx_SendAbort),
        .Tx_RdBuff(Tx_RdBuff), .Tx_StartFCS(Tx_StartFCS), .Tx_WriteFCS(Tx_WriteFCS),
        .Tx_InitZero(Tx_InitZero), .Tx_AbortedTrans(Tx_AbortedTrans), .Tx_Done(Tx_Done),
        .Tx_ByteCnt(Tx_ByteCnt), .Tx_Timeout(Tx_Timeout)
    );

    always #5 Clk = ~Clk;

    // pulse vector: {SendFlag, SendAbort, RdBuff, StartFCS, WriteFCS}
    localparam logic [4:0] P_SF = 5'b10000;
    localparam logic [4:0] P_SA = 5'b01000;
    localparam logic [4:0] P_RD = 5'b00100;
    localparam logic [4:0] P_ST = 5'b00010;
    localparam logic [4:0] P_WF = 5'b00001;

    typedef struct {
        logic       rst, en, ab, nb, fd;
        logic [7:0] sz;
        int         gap;
        logic [4:0] pls;
        logic       vld, dn, iz, abt, to;
        logic [7:0] cnt;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    logic [4:0] sb[$];
    logic       mon_en = 1'b0;
    logic [4:0] w_pls;
    vec_t       tbl[$];

    assign w_pls = {Tx_SendFlag, Tx_SendAbort, Tx_RdBuff, Tx_StartFCS, Tx_WriteFCS};

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, en, ab, nb, fd, input logic [7:0] sz,
                                input int gap, input logic [4:0] pls,
                                input logic vld, dn, iz, abt, input logic [7:0] cnt);
        vec_t v;
        v.rst = rst; v.en = en; v.ab = ab; v.nb = nb; v.fd = fd; v.sz = sz; v.gap = gap;
        v.pls = pls; v.vld = vld; v.dn = dn; v.iz = iz; v.abt = abt; v.cnt = cnt; v.to = 1'b0;
        return v;
    endfunction

    // Scoreboard side: every pulse the DUT emits must match the oldest queued expectation.
    always @(posedge Clk) begin
        #1;
        if (mon_en && w_pls != 5'b0) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pulse_unexpected: got %b want none", w_pls);
            end else begin
                chk("pulse", {3'b0, w_pls}, {3'b0, sb.pop_front()});
            end
        end
    end

    task automatic drive(input vec_t v, input string tag);
        @(negedge Clk);
        Rst = v.rst; Tx_Enable = v.en; Tx_AbortFrame = v.ab;
        Tx_NewByte = v.nb; Tx_FCSDone = v.fd; Tx_FrameSize = v.sz;
        if (v.pls != 5'b0) sb.push_back(v.pls);
        @(posedge Clk);
        #1;
        Rst = 1'b0; Tx_Enable = 1'b0; Tx_AbortFrame = 1'b0; Tx_NewByte = 1'b0; Tx_FCSDone = 1'b0;
        chk({tag, ".valid"}, {7'b0, Tx_ValidFrame},   {7'b0, v.vld});
        chk({tag, ".done"},  {7'b0, Tx_Done},         {7'b0, v.dn});
        chk({tag, ".izero"}, {7'b0, Tx_InitZero},     {7'b0, v.iz});
        chk({tag, ".abrt"},  {7'b0, Tx_AbortedTrans}, {7'b0, v.abt});
        chk({tag, ".tmo"},   {7'b0, Tx_Timeout},      {7'b0, v.to});
        chk({tag, ".cnt"},   Tx_ByteCnt,              v.cnt);
        repeat (v.gap) @(posedge Clk);
    endtask

    initial begin
        vec_t v;
        // reset state
        repeat (2) @(posedge Clk);
        #1;
        chk("rst.valid", {7'b0, Tx_ValidFrame}, 8'd0);
        chk("rst.done",  {7'b0, Tx_Done}, 8'd1);
        chk("rst.cnt",   Tx_ByteCnt, 8'd0);
        chk("rst.pulse", {3'b0, w_pls}, 8'd0);
        chk("rst.misc",  {5'b0, Tx_InitZero, Tx_AbortedTrans, Tx_Timeout}, 8'd0);
        Rst = 1'b0;
        mon_en = 1'b1;

        //                 rst en ab nb fd  sz  gap pulses       vld dn iz abt cnt
        // size 3 normal frame: NewByte every 8 cycles, FCSDone 16 after WriteFCS
        tbl.push_back(mk(0, 1, 0, 0, 0,   3, 7, P_SF | P_ST, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,   3, 7, P_RD,        1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0,   3, 7, P_RD,        1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0,   3, 7, P_RD,        1, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 1, 0,   3, 7, P_WF,        1, 0, 1, 0, 3));
        tbl.push_back(mk(0, 0, 0, 1, 0,   3, 7, 5'b0,        1, 0, 1, 0, 3)); // NewByte in FCS ignored
        tbl.push_back(mk(0, 0, 0, 1, 1,   3, 7, P_SF,        1, 0, 0, 0, 3)); // FCSDone wins over NewByte
        tbl.push_back(mk(0, 0, 0, 1, 0,   3, 3, 5'b0,        0, 1, 0, 0, 3));
        // illegal sizes and abort while idle: nothing changes
        tbl.push_back(mk(0, 1, 0, 0, 0,   0, 2, 5'b0,        0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 1, 0, 0, 0, 127, 2, 5'b0,        0, 1, 0, 0, 3));
        tbl.push_back(mk(0, 0, 1, 0, 0,   5, 2, 5'b0,        0, 1, 0, 0, 3));
        // size 10, abort after 4th RdBuff; Enable mid-frame ignored
        tbl.push_back(mk(0, 1, 0, 0, 0,  10, 2, P_SF | P_ST, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,  10, 2, P_RD,        1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0,  10, 2, P_RD,        1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0,  10, 2, P_RD,        1, 0, 1, 0, 3));
        tbl.push_back(mk(0, 1, 0, 1, 0,   5, 2, P_RD,        1, 0, 1, 0, 4));
        tbl.push_back(mk(0, 0, 1, 0, 0,   5, 2, P_SA,        0, 0, 0, 1, 4));
        tbl.push_back(mk(0, 0, 1, 0, 0,   5, 2, 5'b0,        0, 0, 0, 1, 4)); // abort in ABORT ignored
        tbl.push_back(mk(0, 0, 0, 1, 0,   5, 2, 5'b0,        0, 1, 0, 1, 4));
        // abort together with NewByte in DATA: SendAbort only
        tbl.push_back(mk(0, 1, 0, 0, 0,   2, 1, P_SF | P_ST, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,   2, 1, P_RD,        1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0,   2, 1, P_SA,        0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0,   2, 1, 5'b0,        0, 1, 0, 1, 1));
        // abort together with FCSDone in FCS
        tbl.push_back(mk(0, 1, 0, 0, 0,   1, 1, P_SF | P_ST, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,   1, 1, P_RD,        1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0,   1, 1, P_WF,        1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1,   1, 1, P_SA,        0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0,   1, 1, 5'b0,        0, 1, 0, 1, 1));
        // abort together with NewByte in SFLAG: no byte popped
        tbl.push_back(mk(0, 1, 0, 0, 0,   4, 1, P_SF | P_ST, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0,   4, 1, P_SA,        0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0,   4, 1, 5'b0,        0, 1, 0, 1, 0));
        // largest legal size is accepted
        tbl.push_back(mk(0, 1, 0, 0, 0, 126, 1, P_SF | P_ST, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 126, 1, P_RD,        1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 126, 1, P_RD,        1, 0, 1, 0, 2));
        tbl.push_back(mk(0, 0, 1, 0, 0, 126, 1, P_SA,        0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 126, 2, 5'b0,        0, 1, 0, 1, 2));

        for (int i = 0; i < tbl.size(); i++) drive(tbl[i], $sformatf("row%0d", i));

        // reset mid-frame, then a size-1 frame completes normally
        drive(mk(0, 1, 0, 0, 0, 5, 1, P_SF | P_ST, 1, 0, 0, 0, 0), "rs.start");
        drive(mk(0, 0, 0, 1, 0, 5, 1, P_RD,        1, 0, 1, 0, 1), "rs.b1");
        drive(mk(0, 0, 0, 1, 0, 5, 1, P_RD,        1, 0, 1, 0, 2), "rs.b2");
        drive(mk(1, 0, 0, 0, 0, 5, 1, 5'b0,        0, 1, 0, 0, 0), "rs.reset");
        drive(mk(0, 1, 0, 0, 0, 1, 1, P_SF | P_ST, 1, 0, 0, 0, 0), "rs.s1");
        drive(mk(0, 0, 0, 1, 0, 1, 1, P_RD,        1, 0, 1, 0, 1), "rs.s1b");
        drive(mk(0, 0, 0, 1, 0, 1, 1, P_WF,        1, 0, 1, 0, 1), "rs.s1f");
        drive(mk(0, 0, 0, 0, 1, 1, 1, P_SF,        1, 0, 0, 0, 1), "rs.s1e");
        drive(mk(0, 0, 0, 1, 0, 1, 1, 5'b0,        0, 1, 0, 0, 1), "rs.s1d");

        // FCSDone withheld
        drive(mk(0, 1, 0, 0, 0, 1, 0, P_SF | P_ST, 1, 0, 0, 0, 0), "wd.start");
        drive(mk(0, 0, 0, 1, 0, 1, 0, P_RD,        1, 0, 1, 0, 1), "wd.b1");
        drive(mk(0, 0, 0, 1, 0, 1, 0, P_WF,        1, 0, 1, 0, 1), "wd.fcs");
`ifdef TX_CTRL_TIMEOUT_EN
        for (int k = 1; k < 64; k++)
            drive(mk(0, 0, 0, 0, 0, 1, 0, 5'b0, 1, 0, 1, 0, 1), $sformatf("wd.wait%0d", k));
        v = mk(0, 0, 0, 0, 0, 1, 0, P_SA, 0, 0, 0, 1, 1);
        v.to = 1'b1;
        drive(v, "wd.fire");
        v = mk(0, 0, 0, 1, 0, 1, 1, 5'b0, 0, 1, 0, 1, 1);
        v.to = 1'b1;
        drive(v, "wd.idle");
`else
        for (int k = 1; k <= 70; k++)
            drive(mk(0, 0, 0, 0, 0, 1, 0, 5'b0, 1, 0, 1, 0, 1), $sformatf("wd.wait%0d", k));
        v = mk(0, 0, 1, 0, 0, 1, 0, P_SA, 0, 0, 0, 1, 1);
        drive(v, "wd.abort");
        drive(mk(0, 0, 0, 1, 0, 1, 1, 5'b0, 0, 1, 0, 1, 1), "wd.idle");
`endif

        repeat (3) @(posedge Clk);
        #2;
        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
